// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and width limit for the bit-serial adder
package serial_adder_pkg;
    localparam int WIDTH_MAX = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done request bus between a requester and the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    modport master (output start, a, b, cin_init, input busy, done, result, cout, ovf);
    modport slave  (input start, a, b, cin_init, output busy, done, result, cout, ovf);
endinterface

// File: rtl/myFullAdder.sv
// myFullAdder: single-bit full adder reused every cycle by the serial adder
module myFullAdder (
    input  logic X,
    input  logic Y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = X ^ Y ^ cin;
    assign cout = (X & Y) | (cin & (X ^ Y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per cycle through a single full adder
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end
    state_t           state;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_sum;
    logic             fa_cout;
    myFullAdder u_fa (
        .X    (sr_a[0]),
        .Y    (sr_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr_a    <= '0;
            sr_b    <= '0;
            res     <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                state   <= RUN;
                sr_a    <= bus.a;
                sr_b    <= bus.b;
                carry   <= bus.cin_init;
                bit_cnt <= '0;
                res     <= '0;
                cout_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end else if (state == RUN) begin
            res     <= {fa_sum, res[WIDTH-1:1]};
            carry   <= fa_cout;
            sr_a    <= sr_a >> 1;
            sr_b    <= sr_b >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            // carry still holds the carry into the MSB here, so overflow is settled now
            if (bit_cnt == LAST) begin
                state  <= DONE;
                cout_q <= fa_cout;
                ovf_q  <= carry ^ fa_cout;
            end
        end else begin
            state <= IDLE;
        end
    end
    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = res;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of the serial adder against an arithmetic model
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction
    // two's-complement overflow: same-sign operands giving a result of the other sign
    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        s = model_sum(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction
    // drives one request from an idle DUT and waits (bounded) for done; lat=-1 on timeout
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output logic [W-1:0] r, output logic co, output logic ov, output int lat);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.cin_init = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin_init = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 4 * W; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        r = bus.result;
        co = bus.cout;
        ov = bus.ovf;
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.a = 8'hA5;
        bus.b = 8'h5A;
        bus.cin_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0000 || bus.result !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h cout=%b ovf=%b required all 0",
                     bus.busy, bus.done, bus.result, bus.cout, bus.ovf);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle busy=%b required 0", bus.busy);
        end
    endtask
    task automatic test_directed;
        logic [W-1:0] va [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00};
        logic [W-1:0] vb [6] = '{8'h01, 8'h01, 8'h01, 8'h80, 8'hFF, 8'h00};
        logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] er [6] = '{8'h10, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h00};
        logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] r;
        logic co, ov;
        int lat;
        for (int k = 0; k < 6; k++) begin
            do_add(va[k], vb[k], vc[k], r, co, ov, lat);
            checks++;
            if (lat !== W || r !== er[k] || co !== ec[k] || ov !== eo[k]) begin
                errors++;
                $display("FAIL directed_%0d lat=%0d result=%h cout=%b ovf=%b required lat=%0d result=%h cout=%b ovf=%b",
                         k, lat, r, co, ov, W, er[k], ec[k], eo[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== er[k] || bus.cout !== ec[k]) begin
                errors++;
                $display("FAIL directed_hold_%0d busy=%b done=%b result=%h cout=%b required busy=0 done=0 result=%h cout=%b",
                         k, bus.busy, bus.done, bus.result, bus.cout, er[k], ec[k]);
            end
        end
    endtask
    task automatic test_random;
        logic [W-1:0] x, y, r;
        logic c, co, ov;
        logic [W:0] s;
        int lat;
        for (int k = 0; k < 40; k++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            s = model_sum(x, y, c);
            do_add(x, y, c, r, co, ov, lat);
            checks++;
            if (lat !== W || r !== s[W-1:0] || co !== s[W] || ov !== model_ovf(x, y, c)) begin
                errors++;
                $display("FAIL random_%0d %h+%h+%b lat=%0d result=%h cout=%b ovf=%b required lat=%0d result=%h cout=%b ovf=%b",
                         k, x, y, c, lat, r, co, ov, W, s[W-1:0], s[W], model_ovf(x, y, c));
            end
            repeat (1 + $urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask
    task automatic test_busy_reject;
        int ndone = 0;
        int dpos = -1;
        int busy_bad = 0;
        bus.start = 1'b1;
        bus.a = 8'h0F;
        bus.b = 8'h01;
        bus.cin_init = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= W + 3; i++) begin
            bus.start = (i == 4);
            if (i == 4) begin
                bus.a = 8'h55;
                bus.b = 8'h55;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                dpos = i;
            end
            if (bus.busy !== (i <= W)) busy_bad++;
        end
        checks++;
        if (ndone != 1 || dpos != W || busy_bad != 0 || bus.result !== 8'h10) begin
            errors++;
            $display("FAIL busy_reject dones=%0d at=%0d busy_errs=%0d result=%h required dones=1 at=%0d busy_errs=0 result=10",
                     ndone, dpos, busy_bad, bus.result, W);
        end
    endtask
    task automatic test_reset_mid;
        logic [W-1:0] r;
        logic co, ov;
        int lat;
        int ndone = 0;
        bus.start = 1'b1;
        bus.a = 8'hAB;
        bus.b = 8'h11;
        bus.cin_init = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== '0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b result=%h done=%b required busy=0 result=00 done=0",
                     bus.busy, bus.result, bus.done);
        end
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done dones=%0d required 0", ndone);
        end
        do_add(8'h12, 8'h34, 1'b0, r, co, ov, lat);
        checks++;
        if (lat !== W || r !== 8'h46 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fresh lat=%0d result=%h cout=%b ovf=%b required lat=%0d result=46 cout=0 ovf=0",
                     lat, r, co, ov, W);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_back_to_back;
        logic [W-1:0] x, y;
        logic c;
        logic [W:0] s;
        int pos [$];
        int bad = 0;
        x = W'($urandom);
        y = W'($urandom);
        c = 1'($urandom);
        s = model_sum(x, y, c);
        bus.a = x;
        bus.b = y;
        bus.cin_init = c;
        bus.start = 1'b1;
        // first acceptance at edge 1, then one add every W+2 edges
        for (int i = 1; i <= 3 * (W + 2) + 2; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                pos.push_back(i);
                if (bus.result !== s[W-1:0] || bus.cout !== s[W]) bad++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (pos.size() != 3 || bad != 0) begin
            errors++;
            $display("FAIL back_to_back dones=%0d wrong_results=%0d required dones=3 wrong_results=0", pos.size(), bad);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (pos[k] != 1 + W + k * (W + 2)) begin
                    errors++;
                    $display("FAIL back_to_back_timing_%0d done_at=%0d required %0d", k, pos[k], 1 + W + k * (W + 2));
                end
            end
        end
        repeat (W + 3) @(posedge clk);
        #1;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin_init = 1'b0;
        test_reset;
        test_directed;
        test_busy_reject;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It adds two WIDTH-bit operands using one instance of the team's single-bit full adder, which it reuses across WIDTH consecutive clock cycles. The block holds the operand and result shift registers and the carry flip-flop, and runs a start/done handshake. It sits between a requester (bench or upstream FSM) and the `myFullAdder` datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin_init  input  1  initial carry-in; captured on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse: result, cout and ovf are valid.
- result  output  WIDTH  sum; holds until the next accepted start.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on start=1:
  - load sr_a<=a, sr_b<=b, carry<=cin_init, bit_cnt<=0;
  - clear result, cout and ovf to 0.
- RUN: the full adder receives X=sr_a[0], Y=sr_b[0], cin=carry. Each cycle:
  - result <= {sum, result[WIDTH-1:1]};
  - carry <= cout_fa;
  - sr_a and sr_b shift right by 1;
  - bit_cnt++.
- On the RUN cycle with bit_cnt==WIDTH-1 (the MSB):
  - capture msb_cin<=carry (pre-update value);
  - go to DONE.
- DONE:
  - drive cout=carry, ovf=msb_cin^carry, done=1;
  - return to IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. It is not queued, and operands are not re-sampled.
- a, b and cin_init are don't-care outside the accepted-start cycle.
- Arithmetic is unsigned modulo 2^WIDTH. result is the low WIDTH bits of a + b + cin_init, and cout is bit WIDTH of that sum.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE;
  - busy=0, done=0, result=0, cout=0, ovf=0;
  - internal registers cleared.
- Reset overrides all other activity, including mid-RUN. The operation in flight is abandoned and no done is produced.
- Latency: start accepted at edge k, RUN at edges k+1..k+WIDTH, done=1 in the cycle after edge k+WIDTH (WIDTH+1 cycles after acceptance).
- Throughput: one add per WIDTH+2 cycles when start is held high continuously. Between operations there is 1 DONE cycle plus 1 IDLE cycle.
- busy rises the cycle after the accepted start and falls the cycle after done.
- result, cout and ovf are registered outputs and stay stable from done until the next accepted start.
- The full adder path is combinational within a cycle. There is no internal pipeline.

## Structure
- Shared package `serial_adder_pkg`: state enum type (IDLE, RUN, DONE) and a WIDTH_MAX=32 constant.
- bit_cnt width is $clog2(WIDTH).
- Single sub-module: the existing `myFullAdder`, instantiated once with ports X, Y, cin, sum and cout.
- All other logic (FSM, counter, shift registers, carry flip-flop) lives in `serial_adder_ctrl`.

## Test plan
All scenarios use WIDTH=8.
- Basic add: a=0x0F, b=0x01, cin_init=0 -> done at cycle 9 after acceptance, result=0x10, cout=0, ovf=0.
- Unsigned wrap: a=0xFF, b=0x01, cin_init=0 -> result=0x00, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> result=0x00, cout=1, ovf=1.
- Carry-in: a=0xFF, b=0xFF, cin_init=1 -> result=0xFF, cout=1.
- Busy rejection: pulse start with a=0x55, b=0x55 during RUN of 0x0F+0x01 -> result=0x10, exactly one done pulse, busy profile unchanged.
- Reset mid-op: rst_n=0 at RUN bit 4 -> next cycle busy=0 and result=0, no done. A fresh start of 0x12+0x34 then gives result=0x46.
